acq_sequencer: RTL
==================

Name: acq_sequencer

Overview:
- Acquisition controller that sequences the preamp gain SPI load, periodic ADC conversions and UART framing of both channels.
- Owns arbitration of the shared SPI pins between the amp and ADC engines.
- Sits between the top-level glue and the ampl/adc/uart units, replacing hand-written top-level FSM sequencing.
- Produces a self-synchronising 5-byte frame per sample.

Parameters:
- DIV, 25000, sample period in clk cycles (50 MHz / 25000 = 2 kHz).
- DIV_BIT, 15, width of the period counter.
- TMO, 4096, clk cycles allowed between issuing a conversion and seeing end of conversion.
- TMO_BIT, 13, width of the timeout counter.
- GAIN_RST, 8'h11, gain word loaded on first start after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; begin acquisition from IDLE
- stop  in  1  level; stop after the current frame completes
- gain_wr  in  1  one-cycle strobe; latch gain_in for the next gain load
- gain_in  in  8  new amp gain word
- amp_load  out  1  one-cycle strobe to ampl
- amp_data  out  8  gain word to ampl
- amp_load_ok  in  1  level from ampl; load finished
- adc_conv  out  1  level conversion request to adc
- adc_end_conv  in  1  end-of-conversion from the slow adc domain
- ch0, ch1  in  14 each  adc results, valid at end_conv
- tx_full  in  1  uart tx FIFO full
- wr_uart  out  1  one-cycle write strobe
- w_data  out  8  byte to uart
- spi_own  out  2  00 none, 01 amp, 10 adc; top level muxes SCK/MOSI on this
- busy  out  1  high in any state except IDLE
- err_tmo  out  1  sticky; conversion timed out
- overrun  out  1  sticky; sample tick dropped
- state_dbg  out  3  current state, for LEDs

Behaviour:
- Reset (async, active-high) forces all outputs to 0, state IDLE, gain register = GAIN_RST, pending-gain flag = 0, counters = 0, seq = 0.
- adc_end_conv passes through a 2-flop synchroniser. "Eoc" means a rising edge of the synchronised signal.
- Period counter runs only when busy. It counts 0..DIV-1, then wraps and emits a one-cycle tick.
- IDLE:
  - spi_own=00.
  - On start: state -> GAIN, period counter cleared, sticky flags cleared.
- GAIN:
  - On entry cycle: amp_load=1 for exactly one cycle, amp_data=gain register, spi_own=01.
  - Waits for amp_load_ok=1, then -> ARM.
  - amp_data is held stable throughout GAIN.
- ARM:
  - spi_own=10.
  - Waits for tick.
  - On tick: if the pending-gain flag is set, -> GAIN (clears the flag, copies the latched gain). The following tick triggers the conversion.
  - Otherwise adc_conv=1 and -> CONV.
- CONV:
  - adc_conv is held at 1 and the timeout counter runs.
  - On eoc: capture ch0/ch1, adc_conv=0 next cycle, -> SEND.
  - If the timeout counter reaches TMO-1: adc_conv=0, err_tmo=1, -> ARM. No frame is sent for that sample.
- SEND writes 5 bytes, one per cycle whenever tx_full=0:
  - byte0 = {1, seq[6:0]}
  - byte1 = {0, ch0[13:7]}
  - byte2 = {0, ch0[6:0]}
  - byte3 = {0, ch1[13:7]}
  - byte4 = {0, ch1[6:0]}
  - wr_uart is asserted in the same cycle that w_data is presented.
  - While tx_full=1 the byte index does not advance and wr_uart=0.
  - After byte4, seq increments (wraps 127 -> 0).
  - Then -> IDLE if stop is high, else -> ARM.
- Only byte0 has MSB=1, so the host resynchronises on it.
- A tick arriving in GAIN, CONV or SEND is dropped and sets overrun. The counter keeps its phase and no tick is queued.
- gain_wr in any state latches gain_in and sets the pending flag. A later gain_wr before the load overwrites the latched value (last write wins).
- gain_wr and tick in the same cycle in ARM: the tick is processed with the old flag state and the new gain applies on the following tick.
- stop is sampled only at the end of SEND and in ARM. In ARM, stop -> IDLE immediately. In GAIN/CONV it is ignored until that frame completes.
- start while busy is ignored.
- reset mid-frame aborts immediately. A partially written frame is tolerated by the host via the MSB sync bit.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, GAIN=1, ARM=2, CONV=3, SEND=4)
  - SPI owner codes
  - the frame sync mask 8'h80
  - frame length 5
- Sub-module sync_edge: 2-flop synchroniser plus rising-edge detect for adc_end_conv; reusable for the top-level buttons.
- Period and timeout counters reuse the existing mod_m_counter with M=DIV and M=TMO.

Test Plan:
- Normal run, DIV=100, TMO=50. start pulse, amp_load_ok 3 cycles after amp_load, adc model asserts end_conv 20 cycles after adc_conv, ch0=14'h2ABC, ch1=14'h0155 -> one amp_load pulse with amp_data=8'h11, then bytes 80,55,3C,02,55. The next frame starts 100 cycles after the first conversion, with byte0=81.
- Backpressure: tx_full held high for 10 cycles during byte2 -> no wr_uart while full; byte sequence unchanged; no duplicate or skipped bytes.
- Timeout: adc model never asserts end_conv -> adc_conv drops after 50 cycles, err_tmo=1, no frame emitted; the next tick retries.
- Gain change: gain_wr with gain_in=8'h33 while in SEND -> the next tick produces GAIN with amp_data=33 and spi_own=01. The conversion follows on the subsequent tick.
- Overrun: DIV=20 with a 25-cycle conversion -> overrun=1, and every frame has seq incrementing by exactly 1.
- Stop and reset: stop asserted during CONV -> the frame completes, then IDLE, busy=0. Reset mid-SEND -> all outputs 0 in the same cycle, state_dbg=0.

Source files
------------

// File: rtl/acq_sequencer_pkg.sv
// Shared types and constants for the acquisition sequencer.
// Holds state encoding, SPI owner codes and frame layout helpers.
package acq_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      GAIN = 3'd1,
      ARM  = 3'd2,
      CONV = 3'd3,
      SEND = 3'd4
   } state_t;

   localparam logic [1:0] SPI_NONE = 2'b00;
   localparam logic [1:0] SPI_AMP  = 2'b01;
   localparam logic [1:0] SPI_ADC  = 2'b10;

   localparam logic [7:0] SYNC_MASK = 8'h80;
   localparam int         FRAME_LEN = 5;

   // Byte idx of a frame; only byte 0 carries the sync bit.
   function automatic logic [7:0] frame_byte(
      input logic [2:0]  idx,
      input logic [6:0]  seq,
      input logic [13:0] c0,
      input logic [13:0] c1
   );
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0:    b = SYNC_MASK | {1'b0, seq};
         3'd1:    b = {1'b0, c0[13:7]};
         3'd2:    b = {1'b0, c0[6:0]};
         3'd3:    b = {1'b0, c1[13:7]};
         3'd4:    b = {1'b0, c1[6:0]};
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Bundle of the amp, adc and uart side signals of the sequencer.
// master = sequencer, slave = the peripheral units.
interface acq_sequencer_if;

   logic        amp_load;
   logic [7:0]  amp_data;
   logic        amp_load_ok;
   logic        adc_conv;
   logic        adc_end_conv;
   logic [13:0] ch0;
   logic [13:0] ch1;
   logic        tx_full;
   logic        wr_uart;
   logic [7:0]  w_data;

   modport master (
      output amp_load, amp_data, adc_conv, wr_uart, w_data,
      input  amp_load_ok, adc_end_conv, ch0, ch1, tx_full
   );

   modport slave (
      input  amp_load, amp_data, adc_conv, wr_uart, w_data,
      output amp_load_ok, adc_end_conv, ch0, ch1, tx_full
   );

endinterface

// File: rtl/acq_sequencer_sync_edge.sv
// Two-flop synchroniser with rising-edge detect.
// Usable for any slow asynchronous level (adc eoc, buttons).
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic [2:0] sr;

   // Shift the async level through two sync flops plus one history flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sr <= 3'b000;
      else       sr <= {sr[1:0], din};
   end

   assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/mod_m_counter.sv
// Modulo-M counter with clear and enable.
// max_tick pulses for one enabled cycle at the wrap point.
module mod_m_counter #(
   parameter int M = 10,
   parameter int N = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic max_tick
);

   logic [N-1:0] q;
   logic         last;

   assign last     = (q == N'(M - 1));
   assign max_tick = en & last;

   // Count 0..M-1 while enabled, restart from zero on clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    q <= '0;
      else if (clr) q <= '0;
      else if (en)  q <= last ? '0 : q + N'(1);
   end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: gain load, periodic conversion, framing.
// Also decides which engine owns the shared SPI pins.
module acq_sequencer
   import acq_sequencer_pkg::*;
#(
   parameter int         DIV      = 25000,
   parameter int         DIV_BIT  = 15,
   parameter int         TMO      = 4096,
   parameter int         TMO_BIT  = 13,
   parameter logic [7:0] GAIN_RST = 8'h11
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           stop,
   input  logic           gain_wr,
   input  logic [7:0]     gain_in,
   acq_sequencer_if.master bus,
   output logic [1:0]     spi_own,
   output logic           busy,
   output logic           err_tmo,
   output logic           overrun,
   output logic [2:0]     state_dbg
);

   state_t      state;
   logic [7:0]  gain_reg;
   logic [7:0]  gain_lat;
   logic        pend;
   logic [6:0]  seq;
   logic [2:0]  idx;
   logic [13:0] c0;
   logic [13:0] c1;
   logic        eoc;
   logic        tick;
   logic        tmo_hit;

   sync_edge u_eoc (
      .clk   (clk),
      .reset (reset),
      .din   (bus.adc_end_conv),
      .rise  (eoc)
   );

   mod_m_counter #(.M(DIV), .N(DIV_BIT)) u_per (
      .clk      (clk),
      .reset    (reset),
      .clr      (state == IDLE),
      .en       (state != IDLE),
      .max_tick (tick)
   );

   mod_m_counter #(.M(TMO), .N(TMO_BIT)) u_tmo (
      .clk      (clk),
      .reset    (reset),
      .clr      (state != CONV),
      .en       (state == CONV),
      .max_tick (tmo_hit)
   );

   // A write is offered only when the fifo can take it, so no lag on full.
   assign bus.wr_uart = (state == SEND) && !bus.tx_full;
   assign state_dbg   = state;

   // Main sequencing FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         bus.amp_load <= 1'b0;
         bus.amp_data <= 8'h00;
         bus.adc_conv <= 1'b0;
         bus.w_data   <= 8'h00;
         spi_own      <= SPI_NONE;
         busy         <= 1'b0;
         err_tmo      <= 1'b0;
         overrun      <= 1'b0;
         gain_reg     <= GAIN_RST;
         gain_lat     <= GAIN_RST;
         pend         <= 1'b0;
         seq          <= 7'd0;
         idx          <= 3'd0;
         c0           <= 14'd0;
         c1           <= 14'd0;
      end else begin
         bus.amp_load <= 1'b0;
         if (tick && (state == GAIN || state == CONV || state == SEND))
            overrun <= 1'b1;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state        <= GAIN;
                  bus.amp_load <= 1'b1;
                  bus.amp_data <= gain_reg;
                  spi_own      <= SPI_AMP;
                  busy         <= 1'b1;
                  err_tmo      <= 1'b0;
                  overrun      <= 1'b0;
               end
            end
            GAIN: begin
               // ok may still be high from the last load on entry.
               if (!bus.amp_load && bus.amp_load_ok) begin
                  state   <= ARM;
                  spi_own <= SPI_ADC;
               end
            end
            ARM: begin
               if (stop) begin
                  state   <= IDLE;
                  spi_own <= SPI_NONE;
                  busy    <= 1'b0;
               end else if (tick) begin
                  if (pend) begin
                     state        <= GAIN;
                     pend         <= 1'b0;
                     gain_reg     <= gain_lat;
                     bus.amp_load <= 1'b1;
                     bus.amp_data <= gain_lat;
                     spi_own      <= SPI_AMP;
                  end else begin
                     state        <= CONV;
                     bus.adc_conv <= 1'b1;
                  end
               end
            end
            CONV: begin
               if (eoc) begin
                  c0           <= bus.ch0;
                  c1           <= bus.ch1;
                  bus.adc_conv <= 1'b0;
                  idx          <= 3'd0;
                  bus.w_data   <= frame_byte(3'd0, seq, bus.ch0, bus.ch1);
                  state        <= SEND;
               end else if (tmo_hit) begin
                  bus.adc_conv <= 1'b0;
                  err_tmo      <= 1'b1;
                  state        <= ARM;
               end
            end
            SEND: begin
               if (!bus.tx_full) begin
                  if (idx == 3'(FRAME_LEN - 1)) begin
                     seq        <= seq + 7'd1;
                     idx        <= 3'd0;
                     bus.w_data <= 8'h00;
                     if (stop) begin
                        state   <= IDLE;
                        spi_own <= SPI_NONE;
                        busy    <= 1'b0;
                     end else begin
                        state <= ARM;
                     end
                  end else begin
                     idx        <= idx + 3'd1;
                     bus.w_data <= frame_byte(idx + 3'd1, seq, c0, c1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
         // Placed last so a new write beats the flag clear in ARM.
         if (gain_wr) begin
            gain_lat <= gain_in;
            pend     <= 1'b1;
         end
      end
   end

endmodule
